krnl_dist_rtl_control_m_axi: RTL and testbench

KRNL_DIST_RTL_CONTROL_M_AXI -- requirements
Module: krnl_dist_rtl_control_m_axi

---
 rtl/krnl_dist_rtl_control_m_axi.sv | 149 ++++++++++++++
 tb/tb_krnl_dist_rtl_control_m_axi.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_dist_rtl_control_m_axi.sv
// Command-to-AXI4-Lite master bridge: one register read or write in flight, latency reported per response.
// Latency is min 3 cycles accept-to-rsp_valid; rsp_valid holds until rsp_ready and no command is taken meanwhile.
module krnl_dist_rtl_control_m_axi #(
  parameter int ADDR_WIDTH = 7,
  parameter int LAT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [LAT_WIDTH-1:0]  rsp_cycles,
  output logic [31:0]           AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [31:0]           WDATA,
  output logic [3:0]            WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [31:0]           ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [31:0]           RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {IDLE, WRITE, BWAIT, AR, RWAIT, RSP} state_t;

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic        aw_fin;
  logic        w_fin;
  logic [31:0] addr_ext;

  assign addr_ext = 32'(cmd_addr) & 32'hFFFF_FFFC;
  // A channel counts as finished once its handshake has happened, this cycle or earlier.
  assign aw_fin   = aw_done | (AWVALID & AWREADY);
  assign w_fin    = w_done | (WVALID & WREADY);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_resp   <= 2'b00;
      rsp_cycles <= '0;
      AWADDR     <= 32'h0;
      AWVALID    <= 1'b0;
      WDATA      <= 32'h0;
      WSTRB      <= 4'h0;
      WVALID     <= 1'b0;
      BREADY     <= 1'b0;
      ARADDR     <= 32'h0;
      ARVALID    <= 1'b0;
      RREADY     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      if (state != IDLE && state != RSP && rsp_cycles != {LAT_WIDTH{1'b1}})
        rsp_cycles <= rsp_cycles + 1'b1;

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            rsp_cycles <= {{(LAT_WIDTH-1){1'b0}}, 1'b1};
            if (cmd_write) begin
              AWADDR  <= addr_ext;
              WDATA   <= cmd_wdata;
              WSTRB   <= cmd_wstrb;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WRITE;
            end else begin
              ARADDR  <= addr_ext;
              ARVALID <= 1'b1;
              state   <= AR;
            end
          end
        end
        WRITE: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            BREADY <= 1'b1;
            state  <= BWAIT;
          end
        end
        BWAIT: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_rdata <= 32'h0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RWAIT;
          end
        end
        RWAIT: begin
          if (RVALID) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_krnl_dist_rtl_control_m_axi.sv
// Bench for krnl_dist_rtl_control_m_axi: delay-programmable AXI4-Lite slave, channel monitor and
// a transaction-level model predicting response fields, latency, handshake and valid-hold counts.
module tb_krnl_dist_rtl_control_m_axi;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [6:0]  cmd_addr = 7'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [3:0]  cmd_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_cycles;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = 32'h0;
  logic [1:0]  RRESP = 2'b00;
  logic        RVALID = 1'b0;
  logic        RREADY;

  krnl_dist_rtl_control_m_axi dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  // Slave behaviour: each ready/valid appears after the programmed number of wait cycles.
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn || !AWVALID) begin AWREADY = 1'b0; c = 0; end
      else begin AWREADY = (c >= aw_delay); if (!AWREADY) c++; end
    end
  end

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn || !WVALID) begin WREADY = 1'b0; c = 0; end
      else begin WREADY = (c >= w_delay); if (!WREADY) c++; end
    end
  end

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn || !ARVALID) begin ARREADY = 1'b0; c = 0; end
      else begin ARREADY = (c >= ar_delay); if (!ARREADY) c++; end
    end
  end

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn || !BREADY) begin BVALID = 1'b0; BRESP = 2'b00; c = 0; end
      else begin BVALID = (c >= b_delay); BRESP = BVALID ? b_resp : 2'b00; if (!BVALID) c++; end
    end
  end

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn || !RREADY) begin RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00; c = 0; end
      else begin
        RVALID = (c >= r_delay);
        RDATA  = RVALID ? r_data : 32'h0;
        RRESP  = RVALID ? r_resp : 2'b00;
        if (!RVALID) c++;
      end
    end
  end

  // Channel monitor: counts valid/ready cycles and handshakes, and checks hold-while-stalled.
  int awv_n = 0, wv_n = 0, arv_n = 0, br_n = 0, rr_n = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] last_awaddr = 32'h0, last_wdata = 32'h0, last_araddr = 32'h0;
  logic [3:0]  last_wstrb = 4'h0;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0, p_araddr = 32'h0;
  logic [3:0]  p_wstrb = 4'h0;

  initial begin
    forever begin
      step();
      cyc++;
      if (!aresetn) begin
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
      end else begin
        if (p_awv && !p_awr) begin
          chk("aw_valid_hold", {31'b0, AWVALID}, 32'd1);
          chk("aw_addr_hold", AWADDR, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          chk("w_valid_hold", {31'b0, WVALID}, 32'd1);
          chk("w_data_hold", WDATA, p_wdata);
          chk("w_strb_hold", {28'b0, WSTRB}, {28'b0, p_wstrb});
        end
        if (p_arv && !p_arr) begin
          chk("ar_valid_hold", {31'b0, ARVALID}, 32'd1);
          chk("ar_addr_hold", ARADDR, p_araddr);
        end
        if (AWVALID) awv_n++;
        if (WVALID)  wv_n++;
        if (ARVALID) arv_n++;
        if (BREADY)  br_n++;
        if (RREADY)  rr_n++;
        if (AWVALID && AWREADY) begin aw_hs++; aw_hs_cyc = cyc; last_awaddr = AWADDR; end
        if (WVALID && WREADY) begin w_hs++; w_hs_cyc = cyc; last_wdata = WDATA; last_wstrb = WSTRB; end
        if (ARVALID && ARREADY) begin ar_hs++; last_araddr = ARADDR; end
        if (BVALID && BREADY) b_hs++;
        if (RVALID && RREADY) r_hs++;
        p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
        p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
        p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
      end
    end
  end

  // One complete command: d0/d1/d2 are AW/W/B waits for a write, AR/R waits for a read.
  task automatic run_cmd(input string tag, input bit wr, input logic [6:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int d0, input int d1, input int d2,
                         input logic [1:0] resp, input logic [31:0] rd, input int hold);
    int n, exp_cyc;
    int awv0, wv0, arv0, br0, rr0, aw0, w0, b0, ar0, r0;
    logic [31:0] exp_addr, s_rdata;
    logic [1:0]  s_resp;
    logic [15:0] s_cyc;
    bit stable;
    if (wr) begin
      aw_delay = d0; w_delay = d1; b_delay = d2; b_resp = resp;
      exp_cyc = 3 + ((d0 > d1) ? d0 : d1) + d2;
    end else begin
      ar_delay = d0; r_delay = d1; r_resp = resp; r_data = rd;
      exp_cyc = 3 + d0 + d1;
    end
    exp_addr = {25'b0, addr[6:2], 2'b00};
    awv0 = awv_n; wv0 = wv_n; arv0 = arv_n; br0 = br_n; rr0 = rr_n;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;

    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk({tag, "/cmd_ready_idle"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    step();
    cmd_valid = 1'b0; cmd_addr = 7'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    chk({tag, "/cmd_ready_busy"}, {31'b0, cmd_ready}, 32'd0);

    n = 0;
    while (!rsp_valid && n < 300) begin step(); n++; end
    chk({tag, "/rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "/rsp_rdata"}, rsp_rdata, wr ? 32'h0 : rd);
    chk({tag, "/rsp_resp"}, {30'b0, rsp_resp}, {30'b0, resp});
    chk({tag, "/rsp_cycles"}, {16'b0, rsp_cycles}, 32'(exp_cyc));

    s_rdata = rsp_rdata; s_resp = rsp_resp; s_cyc = rsp_cycles; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_rdata !== s_rdata || rsp_resp !== s_resp ||
          rsp_cycles !== s_cyc || cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "/rsp_stable"}, {31'b0, stable}, 32'd1);

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "/rsp_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "/cmd_ready_back"}, {31'b0, cmd_ready}, 32'd1);

    if (wr) begin
      chk({tag, "/aw_hs"}, 32'(aw_hs - aw0), 32'd1);
      chk({tag, "/w_hs"}, 32'(w_hs - w0), 32'd1);
      chk({tag, "/b_hs"}, 32'(b_hs - b0), 32'd1);
      chk({tag, "/ar_hs"}, 32'(ar_hs - ar0), 32'd0);
      chk({tag, "/awvalid_cycles"}, 32'(awv_n - awv0), 32'(d0 + 1));
      chk({tag, "/wvalid_cycles"}, 32'(wv_n - wv0), 32'(d1 + 1));
      chk({tag, "/bready_cycles"}, 32'(br_n - br0), 32'(d2 + 1));
      chk({tag, "/awaddr"}, last_awaddr, exp_addr);
      chk({tag, "/wdata"}, last_wdata, wd);
      chk({tag, "/wstrb"}, {28'b0, last_wstrb}, {28'b0, ws});
    end else begin
      chk({tag, "/ar_hs"}, 32'(ar_hs - ar0), 32'd1);
      chk({tag, "/r_hs"}, 32'(r_hs - r0), 32'd1);
      chk({tag, "/aw_hs"}, 32'(aw_hs - aw0), 32'd0);
      chk({tag, "/arvalid_cycles"}, 32'(arv_n - arv0), 32'(d0 + 1));
      chk({tag, "/rready_cycles"}, 32'(rr_n - rr0), 32'(d1 + 1));
      chk({tag, "/araddr"}, last_araddr, exp_addr);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0;
    bit wr;
    int d0, d1, d2, hold;

    // Reset values while held in reset.
    step();
    step();
    chk("rst/cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst/valids", {27'b0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    chk("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst/rsp_rdata", rsp_rdata, 32'h0);
    chk("rst/rsp_resp", {30'b0, rsp_resp}, 32'd0);
    chk("rst/rsp_cycles", {16'b0, rsp_cycles}, 32'd0);
    chk("rst/awaddr", AWADDR, 32'h0);
    chk("rst/araddr", ARADDR, 32'h0);
    chk("rst/wdata", WDATA, 32'h0);
    chk("rst/wstrb", {28'b0, WSTRB}, 32'd0);
    #2 aresetn = 1'b1;
    #1 chk("rst/cmd_ready_pre_edge", {31'b0, cmd_ready}, 32'd0);
    step();
    chk("rst/cmd_ready_first_edge", {31'b0, cmd_ready}, 32'd1);

    // Zero-wait write: AW and W handshake together, 3-cycle latency.
    run_cmd("wr_zero", 1'b1, 7'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
    chk("wr_zero/aw_w_same_cycle", 32'(aw_hs_cyc), 32'(w_hs_cyc));

    // AWREADY late by 4 cycles, WREADY immediate.
    run_cmd("wr_aw_late", 1'b1, 7'h24, 32'h12345678, 4'h5, 4, 0, 0, 2'b00, 32'h0, 0);
    // WREADY late, AWREADY immediate, slave error passed through.
    run_cmd("wr_w_late", 1'b1, 7'h3F, 32'hA5A5_0F0F, 4'h9, 0, 3, 2, 2'b10, 32'h0, 1);

    // Read with two R wait cycles.
    run_cmd("rd_wait", 1'b0, 7'h00, 32'h0, 4'h0, 0, 2, 0, 2'b00, 32'h0000000E, 0);
    // Unmapped read returns SLVERR.
    run_cmd("rd_err", 1'b0, 7'h7C, 32'h0, 4'h0, 1, 0, 0, 2'b10, 32'hCAFE_F00D, 0);
    // Response held for 10 cycles by rsp_ready.
    run_cmd("rd_hold", 1'b0, 7'h48, 32'h0, 4'h0, 2, 1, 0, 2'b11, 32'h8000_0001, 10);

    // Randomized mix.
    for (int k = 0; k < 14; k++) begin
      wr = 1'($urandom);
      d0 = $urandom_range(0, 5);
      d1 = $urandom_range(0, 5);
      d2 = $urandom_range(0, 4);
      hold = $urandom_range(0, 3);
      run_cmd($sformatf("rnd%0d", k), wr, 7'($urandom), $urandom, 4'($urandom),
              d0, d1, d2, 2'($urandom), $urandom, hold);
    end

    // Reset while waiting for B: nothing completes, bridge restarts cleanly.
    aw_delay = 0; w_delay = 0; b_delay = 40; b_resp = 2'b00;
    b0 = b_hs;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h20; cmd_wdata = 32'h0BAD_CAFE; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!BREADY && n < 20) begin step(); n++; end
    chk("bwait_rst/reached_bwait", {31'b0, BREADY}, 32'd1);
    step();
    #2 aresetn = 1'b0;
    #1;
    chk("bwait_rst/valids_async", {27'b0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 32'd0);
    chk("bwait_rst/rsp_valid_async", {31'b0, rsp_valid}, 32'd0);
    chk("bwait_rst/cmd_ready_async", {31'b0, cmd_ready}, 32'd0);
    chk("bwait_rst/rsp_cycles_async", {16'b0, rsp_cycles}, 32'd0);
    step();
    step();
    #2 aresetn = 1'b1;
    #1 chk("bwait_rst/cmd_ready_pre_edge", {31'b0, cmd_ready}, 32'd0);
    step();
    chk("bwait_rst/cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("bwait_rst/no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("bwait_rst/no_b_hs", 32'(b_hs - b0), 32'd0);
    chk("bwait_rst/bready_idle", {31'b0, BREADY}, 32'd0);

    // Normal operation after the mid-transaction reset.
    run_cmd("post_rst", 1'b0, 7'h0C, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h1357_9BDF, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
